// File: rtl/cam_insert_ctrl.sv
// Insert controller for an external CAM: search for a key, allocate an entry on miss, report hit/index.
// Optional macro CAM_CTRL_EVICT_EN: on a miss with the CAM full, overwrite entries round-robin instead of rejecting.
module cam_insert_ctrl #(
    parameter int unsigned ARRAY_WIDTH_LOG2 = 5,
    parameter int unsigned ARRAY_SIZE_LOG2  = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid_i,
    input  logic [2**ARRAY_WIDTH_LOG2-1:0]  req_data_i,
    output logic                            req_ready_o,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic                            resp_hit_o,
    output logic                            resp_full_o,
    output logic [ARRAY_SIZE_LOG2-1:0]      resp_index_o,
    output logic                            cam_search_o,
    output logic [2**ARRAY_WIDTH_LOG2-1:0]  cam_search_data_o,
    input  logic                            cam_search_valid_i,
    input  logic [ARRAY_SIZE_LOG2-1:0]      cam_search_index_i,
    output logic                            cam_write_o,
    output logic [ARRAY_SIZE_LOG2-1:0]      cam_write_index_o,
    output logic [2**ARRAY_WIDTH_LOG2-1:0]  cam_write_data_o,
    output logic [ARRAY_SIZE_LOG2:0]        occupancy_o
);

    localparam int unsigned KEY_W   = 2**ARRAY_WIDTH_LOG2;
    localparam int unsigned IDX_W   = ARRAY_SIZE_LOG2;
    localparam int unsigned OCC_W   = ARRAY_SIZE_LOG2 + 1;
    localparam int unsigned ENTRIES = 2**ARRAY_SIZE_LOG2;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(ENTRIES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W-1:0]   target_q, target_d;
    logic [IDX_W-1:0]   fill_ptr_q, fill_ptr_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;
    logic               resp_hit_q, resp_hit_d;
    logic               resp_full_q, resp_full_d;
    logic [IDX_W-1:0]   resp_index_q, resp_index_d;

    // Registered strobes and buses, loaded from the next-state decode
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               cam_search_q, cam_search_d;
    logic [KEY_W-1:0]   cam_search_data_q, cam_search_data_d;
    logic               cam_write_q, cam_write_d;
    logic [IDX_W-1:0]   cam_write_index_q, cam_write_index_d;
    logic [KEY_W-1:0]   cam_write_data_q, cam_write_data_d;

`ifdef CAM_CTRL_EVICT_EN
    logic [IDX_W-1:0]   evict_ptr_q, evict_ptr_d;
    logic               evicting_q, evicting_d;
`endif

    logic               full;
    assign full = (occupancy_q == OCC_FULL);

    // Next-state, bookkeeping and output decode
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        target_d     = target_q;
        fill_ptr_d   = fill_ptr_q;
        occupancy_d  = occupancy_q;
        resp_hit_d   = resp_hit_q;
        resp_full_d  = resp_full_q;
        resp_index_d = resp_index_q;
`ifdef CAM_CTRL_EVICT_EN
        evict_ptr_d  = evict_ptr_q;
        evicting_d   = evicting_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    key_d   = req_data_i;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (cam_search_valid_i) begin
                    resp_hit_d   = 1'b1;
                    resp_full_d  = 1'b0;
                    resp_index_d = cam_search_index_i;
                    state_d      = RESP;
                end else if (!full) begin
                    target_d     = fill_ptr_q;
                    resp_hit_d   = 1'b0;
                    resp_full_d  = 1'b0;
                    resp_index_d = fill_ptr_q;
`ifdef CAM_CTRL_EVICT_EN
                    evicting_d   = 1'b0;
`endif
                    state_d      = WRITE;
                end else begin
`ifdef CAM_CTRL_EVICT_EN
                    target_d     = evict_ptr_q;
                    resp_hit_d   = 1'b0;
                    resp_full_d  = 1'b0;
                    resp_index_d = evict_ptr_q;
                    evicting_d   = 1'b1;
                    state_d      = WRITE;
`else
                    resp_hit_d   = 1'b0;
                    resp_full_d  = 1'b1;
                    resp_index_d = '0;
                    state_d      = RESP;
`endif
                end
            end
            WRITE: begin
                state_d = RESP;
`ifdef CAM_CTRL_EVICT_EN
                if (evicting_q) begin
                    evict_ptr_d = evict_ptr_q + IDX_W'(1);
                end else begin
                    fill_ptr_d = fill_ptr_q + IDX_W'(1);
                    if (!full) occupancy_d = occupancy_q + OCC_W'(1);
                end
`else
                fill_ptr_d = fill_ptr_q + IDX_W'(1);
                if (!full) occupancy_d = occupancy_q + OCC_W'(1);
`endif
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_hit_d   = 1'b0;
                    resp_full_d  = 1'b0;
                    resp_index_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d       = (state_d == IDLE);
        resp_valid_d      = (state_d == RESP);
        cam_search_d      = (state_d == SEARCH);
        cam_search_data_d = (state_d == SEARCH) ? key_d : '0;
        cam_write_d       = (state_d == WRITE);
        cam_write_index_d = (state_d == WRITE) ? target_d : '0;
        cam_write_data_d  = (state_d == WRITE) ? key_d : '0;
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            key_q             <= '0;
            target_q          <= '0;
            fill_ptr_q        <= '0;
            occupancy_q       <= '0;
            resp_hit_q        <= 1'b0;
            resp_full_q       <= 1'b0;
            resp_index_q      <= '0;
            req_ready_q       <= 1'b0;
            resp_valid_q      <= 1'b0;
            cam_search_q      <= 1'b0;
            cam_search_data_q <= '0;
            cam_write_q       <= 1'b0;
            cam_write_index_q <= '0;
            cam_write_data_q  <= '0;
`ifdef CAM_CTRL_EVICT_EN
            evict_ptr_q       <= '0;
            evicting_q        <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            key_q             <= key_d;
            target_q          <= target_d;
            fill_ptr_q        <= fill_ptr_d;
            occupancy_q       <= occupancy_d;
            resp_hit_q        <= resp_hit_d;
            resp_full_q       <= resp_full_d;
            resp_index_q      <= resp_index_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            cam_search_q      <= cam_search_d;
            cam_search_data_q <= cam_search_data_d;
            cam_write_q       <= cam_write_d;
            cam_write_index_q <= cam_write_index_d;
            cam_write_data_q  <= cam_write_data_d;
`ifdef CAM_CTRL_EVICT_EN
            evict_ptr_q       <= evict_ptr_d;
            evicting_q        <= evicting_d;
`endif
        end
    end

    assign req_ready_o       = req_ready_q;
    assign resp_valid_o      = resp_valid_q;
    assign resp_hit_o        = resp_hit_q;
    assign resp_full_o       = resp_full_q;
    assign resp_index_o      = resp_index_q;
    assign cam_search_o      = cam_search_q;
    assign cam_search_data_o = cam_search_data_q;
    assign cam_write_o       = cam_write_q;
    assign cam_write_index_o = cam_write_index_q;
    assign cam_write_data_o  = cam_write_data_q;
    assign occupancy_o       = occupancy_q;

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Directed bench for cam_insert_ctrl with a behavioural 32x32 CAM attached.
module tb_cam_insert_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_data;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic        resp_full;
    logic [4:0]  resp_index;
    logic        cam_search;
    logic [31:0] cam_search_data;
    logic        cam_search_valid;
    logic [4:0]  cam_search_index;
    logic        cam_write;
    logic [4:0]  cam_write_index;
    logic [31:0] cam_write_data;
    logic [5:0]  occupancy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cam_insert_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_data_i         (req_data),
        .req_ready_o        (req_ready),
        .resp_valid_o       (resp_valid),
        .resp_ready_i       (resp_ready),
        .resp_hit_o         (resp_hit),
        .resp_full_o        (resp_full),
        .resp_index_o       (resp_index),
        .cam_search_o       (cam_search),
        .cam_search_data_o  (cam_search_data),
        .cam_search_valid_i (cam_search_valid),
        .cam_search_index_i (cam_search_index),
        .cam_write_o        (cam_write),
        .cam_write_index_o  (cam_write_index),
        .cam_write_data_o   (cam_write_data),
        .occupancy_o        (occupancy)
    );

    // CAM model: combinational lowest-index match, write on strobe, cleared by the shared reset
    logic [31:0] cam_key [32];
    logic [31:0] cam_vld;

    always_comb begin
        cam_search_valid = 1'b0;
        cam_search_index = '0;
        for (int i = 31; i >= 0; i--) begin
            if (cam_search && cam_vld[i] && cam_key[i] == cam_search_data) begin
                cam_search_valid = 1'b1;
                cam_search_index = 5'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cam_vld <= '0;
        end else if (cam_write) begin
            cam_key[cam_write_index] <= cam_write_data;
            cam_vld[cam_write_index] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One full insert transaction, accepted on the first edge and drained with resp_ready high
    task automatic insert(input logic [31:0] key, input logic exp_write, input logic exp_hit,
                          input logic exp_full, input logic [4:0] exp_idx, input logic [5:0] exp_occ);
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = key;
        tick();
        req_valid = 1'b0;
        check("search_strobe", 32'(cam_search), 32'd1);
        check("search_data", cam_search_data, key);
        check("busy_ready", 32'(req_ready), 32'd0);
        tick();
        check("write_strobe", 32'(cam_write), 32'(exp_write));
        if (exp_write) begin
            check("write_index", 32'(cam_write_index), 32'(exp_idx));
            check("write_data", cam_write_data, key);
            check("write_no_search", 32'(cam_search), 32'd0);
            tick();
            check("post_write_strobe", 32'(cam_write), 32'd0);
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_hit", 32'(resp_hit), 32'(exp_hit));
        check("resp_full", 32'(resp_full), 32'(exp_full));
        check("resp_index", 32'(resp_index), 32'(exp_idx));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("back_idle_ready", 32'(req_ready), 32'd1);
        check("back_idle_valid", 32'(resp_valid), 32'd0);
        check("occupancy", 32'(occupancy), 32'(exp_occ));
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_data   = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_search", 32'(cam_search), 32'd0);
        check("rst_write", 32'(cam_write), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_index", 32'(resp_index), 32'd0);
        check("rst_wdata", cam_write_data, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // First insert allocates entry 0, repeat hits it
        insert(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0, 6'd1);
        insert(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0, 6'd1);

        // Response held with resp_ready low
        req_valid = 1'b1;
        req_data  = 32'h0000_1234;
        tick();
        req_valid = 1'b0;
        tick();
        check("hold_write_idx", 32'(cam_write_index), 32'd1);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_index", 32'(resp_index), 32'd1);
            check("hold_hit", 32'(resp_hit), 32'd0);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_strobes", 32'({cam_search, cam_write}), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("hold_release", 32'(req_ready), 32'd1);
        check("hold_occ", 32'(occupancy), 32'd2);

        // Reset landing in WRITE aborts the transaction
        req_valid = 1'b1;
        req_data  = 32'h0000_5678;
        tick();
        req_valid = 1'b0;
        tick();
        check("abort_in_write", 32'(cam_write), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_write", 32'(cam_write), 32'd0);
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_occ", 32'(occupancy), 32'd0);
        check("abort_ready_in_rst", 32'(req_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("abort_ready_after", 32'(req_ready), 32'd1);

        // Fill all 32 entries, then miss while full
        for (int k = 0; k < 32; k++) begin
            insert(32'(k), 1'b1, 1'b0, 1'b0, 5'(k), 6'(k + 1));
        end
`ifdef CAM_CTRL_EVICT_EN
        insert(32'd100, 1'b1, 1'b0, 1'b0, 5'd0, 6'd32);
        insert(32'd101, 1'b1, 1'b0, 1'b0, 5'd1, 6'd32);
        insert(32'd100, 1'b0, 1'b1, 1'b0, 5'd0, 6'd32);
`else
        insert(32'd100, 1'b0, 1'b0, 1'b1, 5'd0, 6'd32);
        insert(32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd32);
`endif
        insert(32'd5, 1'b0, 1'b1, 1'b0, 5'd5, 6'd32);
        insert(32'd31, 1'b0, 1'b1, 1'b0, 5'd31, 6'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_insert_ctrl.md
CAM_INSERT_CTRL -- requirements
Module: cam_insert_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH_LOG2, default 5, meaning log2 of CAM entry width (entry width = 2**ARRAY_WIDTH_LOG2 bits).
REQ-002 SHALL have parameter ARRAY_SIZE_LOG2, default 5, meaning log2 of CAM entry count (N = 2**ARRAY_SIZE_LOG2).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, rising edge; reset  in  1  synchronous active-high reset.
REQ-004 req_valid_i  in  1  client insert request; req_data_i  in  2**ARRAY_WIDTH_LOG2  key to insert; req_ready_o  out  1  controller can accept a request.
REQ-005 resp_valid_o  out  1  response pending; resp_ready_i  in  1  client accepts response; resp_hit_o  out  1  key already present; resp_full_o  out  1  insert rejected, CAM full; resp_index_o  out  ARRAY_SIZE_LOG2  entry index of key.
REQ-006 cam_search_o  out  1  CAM search strobe; cam_search_data_o  out  2**ARRAY_WIDTH_LOG2  search key; cam_search_valid_i  in  1  CAM hit, same cycle; cam_search_index_i  in  ARRAY_SIZE_LOG2  lowest matching index, same cycle.
REQ-007 cam_write_o  out  1  CAM write strobe; cam_write_index_o  out  ARRAY_SIZE_LOG2  write index; cam_write_data_o  out  2**ARRAY_WIDTH_LOG2  write data.
REQ-008 occupancy_o  out  ARRAY_SIZE_LOG2+1  number of entries allocated (0..N).

Function
REQ-009 SHALL implement FSM states IDLE, SEARCH, WRITE, RESP.
REQ-010 IDLE: req_ready_o=1; on req_valid_i=1, SHALL capture req_data_i into key register and go to SEARCH; otherwise stay.
REQ-011 SEARCH: cam_search_o=1, cam_search_data_o=key; SHALL sample cam_search_valid_i/cam_search_index_i at end of cycle.
REQ-012 SEARCH hit: resp_hit_o=1, resp_index_o=cam_search_index_i, next RESP; no write, occupancy unchanged.
REQ-013 SEARCH miss, occupancy_o<N: next WRITE with target index = fill_ptr.
REQ-014 SEARCH miss, occupancy_o==N: behaviour per REQ-024/REQ-025.
REQ-015 WRITE: cam_write_o=1, cam_write_index_o=target, cam_write_data_o=key for exactly one cycle; resp_hit_o=0, resp_index_o=target; fill_ptr and occupancy_o increment at end of cycle (non-evict case); next RESP.
REQ-016 RESP: resp_valid_o=1 with hit/full/index held stable until resp_ready_i=1; on resp_ready_i=1 go to IDLE.
REQ-017 req_ready_o SHALL be 0 in every state except IDLE; cam_search_o=0 outside SEARCH; cam_write_o=0 outside WRITE.
REQ-018 Latency, accept edge = cycle 0: hit -> resp_valid_o cycle 2; miss -> write cycle 2, resp_valid_o cycle 3; with resp_ready_i=1, next request accepted one cycle after response.
REQ-019 fill_ptr is ARRAY_SIZE_LOG2 bits and wraps N-1 -> 0; occupancy_o saturates at N, never exceeds N.
REQ-020 Reset asserted in any state SHALL abort the operation with no further CAM strobe; a pending response SHALL be discarded.

Reset
REQ-021 On reset: state IDLE, fill_ptr=0, evict_ptr=0, occupancy_o=0, key register=0.
REQ-022 During and after reset: req_ready_o=0 while reset=1, 1 in first cycle after; resp_valid_o=0, resp_hit_o=0, resp_full_o=0, resp_index_o=0, cam_search_o=0, cam_write_o=0, all data/index outputs 0.
REQ-023 Controller's occupancy is valid only if CAM is reset together with it (shared reset net).

Configuration
REQ-024 Without CAM_CTRL_EVICT_EN: miss while full SHALL go to RESP with resp_full_o=1, resp_hit_o=0, resp_index_o=0, no CAM write.
REQ-025 With CAM_CTRL_EVICT_EN: miss while full SHALL go to WRITE with target=evict_ptr; evict_ptr increments (wraps N-1 -> 0) after write; occupancy_o stays N; resp_full_o never asserted.

Verification
REQ-026 Reset, then insert 0xDEADBEEF -> search cycle, write idx 0, resp hit=0 index=0, occupancy_o=1.
REQ-027 Insert 0xDEADBEEF again -> no cam_write_o, resp hit=1 index=0 at cycle 2, occupancy_o=1.
REQ-028 Insert 32 distinct keys 0..31 then key 100 -> indices 0..31 in order; key 100 gives full=1 (no macro) or write idx 0 then idx 1 on next miss (macro defined).
REQ-029 Hold resp_ready_i=0 for 5 cycles during RESP -> resp_valid_o and payload stable, req_ready_o=0, no CAM strobes.
REQ-030 Assert reset during WRITE state -> cam_write_o=0 next cycle, resp_valid_o=0, occupancy_o=0, req_ready_o=1 in first cycle after reset.
